uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

Receive-side UART for 8 data bits, no parity, and 1 stop bit (8N1), running directly on the 12 MHz board clock. It recovers bytes sent from the FTDI bridge and delivers each one on a valid/ready handshake, flagging framing errors and overruns. It pairs with the existing 8N1 transmitter, so the top level can loop back or process host characters, e.g. echoing ASCII digits.

## Interface
Parameters:
- `CLK_HZ`, default 12000000: `hwclk` frequency in Hz.
- `BAUD`, default 9600: line rate.
- `CPB`, default `CLK_HZ/BAUD` = 1250: `hwclk` cycles per bit. Must be ≥ 4.
- `HALF`, default `CPB/2` = 625 (truncating divide): cycles from start-bit detection to the start-bit centre.

Ports:
- `hwclk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `ftdi_rx`, in, 1: asynchronous serial line, idle high.
- `rxbyte`, out, 8: received byte. Reset 0.
- `rxvalid`, out, 1: `rxbyte` holds an unconsumed byte. Reset 0.
- `rxready`, in, 1: consumer accepts the byte.
- `rxerr`, out, 1: one-cycle framing-error pulse. Reset 0.
- `rxovr`, out, 1: one-cycle overrun pulse. Reset 0.

## Operation
- **Synchronizer:** two flops, `meta` then `rx_s`, both reset to 1 so reset never produces a false start. All decisions use `rx_s`.
- **Bit counter:** 11-bit, cleared on every state entry, increments every cycle.
- **States:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rx_s` = 0, go to START.
  - START: at count `HALF-1`, sample `rx_s`. If 0, go to DATA with bit index 0. If 1 (glitch), go to IDLE with no output.
  - DATA: at count `CPB-1`, sample `rx_s` into shift bit[index], LSB first. After index 7, go to STOP.
  - STOP: at count `CPB-1`, sample `rx_s`.
    - If 1: deliver the byte (see handshake) and go to IDLE.
    - If 0: pulse `rxerr`, discard the byte, go to BREAK.
  - BREAK: wait until `rx_s` = 1, then go to IDLE. A stuck-low line therefore produces exactly one `rxerr`.
- **Handshake:**
  - A transfer occurs on a cycle where `rxvalid & rxready` are both high.
  - `rxvalid` falls after that transfer unless a new byte is delivered on the same edge.
  - `rxbyte` is stable while `rxvalid` = 1.
- **Delivery:**
  - If `rxvalid` = 0, or a transfer happens on the same cycle: load `rxbyte` and set `rxvalid` = 1.
  - Otherwise: keep the old byte, drop the new one, and pulse `rxovr`.
- **Asynchronous reset mid-frame:** all state returns to IDLE and all outputs to their reset values immediately. The partial byte is lost.

## Timing
- t0 is the first `hwclk` edge that samples `ftdi_rx` low.
  - START is entered at edge t0+2.
  - The start bit is sampled at t0+2+`HALF`.
  - Data bit i is sampled at t0+2+`HALF`+(i+1)·`CPB`.
  - The stop bit is sampled at t0+2+`HALF`+9·`CPB`.
- `rxvalid`, `rxbyte`, `rxerr` and `rxovr` update on the stop-sample edge. With defaults this is t0+11877.
- The receiver is back in IDLE on the edge after the stop sample. It accepts a new start bit half a bit early, tolerating ±4 % baud mismatch.
- `rxready` is combinationally sampled. There is no combinational path from `rxready` to any output.

## Structure
- Package `uart_pkg` holds:
  - the state enum `rx_state_t` (IDLE/START/DATA/STOP/BREAK);
  - the constants `UART_CLK_HZ` = 12000000 and `UART_BAUD` = 9600;
  - the function `cpb(clk_hz, baud)`, shared with the transmitter.
- Sub-module `uart_sync2`: a 2-flop synchronizer with a reset-value parameter. It is reusable for other async inputs.
- FSM, counter, shift register and output register live in one always block plus next-state logic.

## Test plan
- **Single byte:** send 0x35 ('5') at 9600 baud with `rxready` held at 1 → `rxvalid` high for exactly 1 cycle at t0+11877 with `rxbyte` = 0x35, and `rxerr` = `rxovr` = 0.
- **Back-to-back with handshake:** send 0x30..0x39 with `rxready` = 0. Consume each byte within 100 cycles of `rxvalid` → ten bytes received in order, no `rxovr`.
- **Overrun:** send 0x41 then 0x42 with `rxready` = 0 throughout → `rxbyte` stays 0x41, one `rxovr` pulse at the second stop sample.
- **Framing/break:** hold the line low for 20 bit times → one `rxerr` pulse at t0+11877, no `rxvalid`. Then send 0x55 after the line goes high → 0x55 received.
- **Glitch:** drive `ftdi_rx` low for 300 cycles → no output, FSM back in IDLE by t0+628.
- **Reset mid-frame:** assert `rst` during bit 4 of 0xA5 → outputs 0 immediately. After release, a clean 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, board constants and bit-timing helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  localparam int UART_CLK_HZ = 12000000;
  localparam int UART_BAUD = 9600;
  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_8n1_if.sv
// uart_rx_8n1_if: received-byte valid/ready handshake plus error pulses
interface uart_rx_8n1_if;
  import uart_pkg::*;
  logic [7:0] rxbyte;
  logic rxvalid;
  logic rxready;
  logic rxerr;
  logic rxovr;
  modport master (output rxbyte, rxvalid, rxerr, rxovr, input rxready);
  modport slave (input rxbyte, rxvalid, rxerr, rxovr, output rxready);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input, reset to RST_VAL
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q <= r_meta;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with valid/ready output, framing-error and overrun pulses
module uart_rx_8n1 import uart_pkg::*; #(
  parameter int CLK_HZ = UART_CLK_HZ,
  parameter int BAUD = UART_BAUD,
  parameter int CPB = cpb(CLK_HZ, BAUD),
  parameter int HALF = CPB / 2
) (
  input logic hwclk,
  input logic rst,
  input logic ftdi_rx,
  uart_rx_8n1_if.master rx
);
  localparam logic [10:0] L_HALF_M1 = 11'(HALF - 1);
  localparam logic [10:0] L_CPB_M1 = 11'(CPB - 1);
  rx_state_t r_state, w_next;
  logic [10:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift, r_byte;
  logic r_valid, r_err, r_ovr;
  logic w_rx, w_half, w_bit, w_xfer, w_deliver, w_ferr, w_load, w_clr;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(hwclk), .rst(rst), .i_d(ftdi_rx), .o_q(w_rx));
  always_comb begin
    w_half = r_cnt == L_HALF_M1;
    w_bit = r_cnt == L_CPB_M1;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_rx ? IDLE : START;
      START:   w_next = !w_half ? START : (w_rx ? IDLE : DATA);
      DATA:    w_next = (w_bit && r_idx == 3'd7) ? STOP : DATA;
      STOP:    w_next = !w_bit ? STOP : (w_rx ? IDLE : BREAK);
      BREAK:   w_next = w_rx ? IDLE : BREAK;
      default: w_next = IDLE;
    endcase
    w_deliver = r_state == STOP && w_bit && w_rx;
    w_ferr = r_state == STOP && w_bit && !w_rx;
    w_xfer = r_valid && rx.rxready;
    w_load = w_deliver && (!r_valid || w_xfer);
    // DATA re-arms the counter per bit without leaving the state
    w_clr = w_next != r_state || (r_state == DATA && w_bit);
  end
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_byte <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_clr ? '0 : r_cnt + 11'd1;
      r_idx <= r_state != DATA ? 3'd0 : r_idx + 3'(w_bit);
      if (r_state == DATA && w_bit) r_shift <= {w_rx, r_shift[7:1]};
      if (w_load) r_byte <= r_shift;
      r_valid <= w_load || (r_valid && !w_xfer);
      r_err <= w_ferr;
      r_ovr <= w_deliver && !w_load;
    end
  end
  assign rx.rxbyte = r_byte;
  assign rx.rxvalid = r_valid;
  assign rx.rxerr = r_err;
  assign rx.rxovr = r_ovr;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: default-rate timing check plus table, corner-case and random tests on a fast instance
module tb_uart_rx_8n1;
  localparam int FCPB = 16;
  localparam int FHALF = 8;
  localparam int FSTOP = 2 + FHALF + 9 * FCPB;
  localparam int DCPB = 1250;
  localparam int DSTOP = 11877;
  typedef struct {logic [7:0] d; bit stop; bit exp_v; bit exp_e;} vec_t;
  logic hwclk = 1'b0;
  logic rst = 1'b1;
  logic ftdi = 1'b1;
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  int t0, t1, bv, bx, be, bo, nerr, w;
  logic [7:0] xq[$];
  int vq[$], eq[$], oq[$];
  logic [7:0] exp_q[$];
  logic pv = 1'b0;
  vec_t tbl[7];
  uart_rx_8n1_if if_d();
  uart_rx_8n1_if if_f();
  uart_rx_8n1 dut_d (.hwclk(hwclk), .rst(rst), .ftdi_rx(ftdi), .rx(if_d));
  uart_rx_8n1 #(.CPB(FCPB), .HALF(FHALF)) dut_f (.hwclk(hwclk), .rst(rst), .ftdi_rx(ftdi), .rx(if_f));
  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;
  // Fast-instance event log: transfers, valid rises, error and overrun pulses with their edge number
  always @(negedge hwclk) begin
    if (rst) pv <= 1'b0;
    else begin
      if (if_f.rxvalid && if_f.rxready) xq.push_back(if_f.rxbyte);
      if (if_f.rxvalid && !pv) vq.push_back(cyc);
      if (if_f.rxerr) eq.push_back(cyc);
      if (if_f.rxovr) oq.push_back(cyc);
      pv <= if_f.rxvalid;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic align(output int t);
    @(posedge hwclk);
    #1;
    t = cyc + 1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask
  task automatic at(input int c);
    @(negedge hwclk);
    while (cyc < c) @(negedge hwclk);
  endtask
  task automatic frame(input logic [7:0] d, input bit stop, input int c);
    ftdi = 1'b0;
    repeat (c) @(posedge hwclk);
    #1;
    for (int i = 0; i < 8; i++) begin
      ftdi = d[i];
      repeat (c) @(posedge hwclk);
      #1;
    end
    ftdi = stop;
    repeat (c) @(posedge hwclk);
    #1;
    ftdi = 1'b1;
  endtask
  task automatic snap();
    bv = vq.size();
    bx = xq.size();
    be = eq.size();
    bo = oq.size();
  endtask
  task automatic expect_one(input string nm, input logic [7:0] d, input int t);
    chk({nm, "_nvalid"}, vq.size() - bv, 1);
    if (vq.size() > bv) chk({nm, "_cycle"}, vq[bv], t + FSTOP);
    if (xq.size() > bx) chk({nm, "_byte"}, xq[bx], d);
    else chk({nm, "_nxfer"}, xq.size() - bx, 1);
    chk({nm, "_nerr"}, eq.size() - be, 0);
    chk({nm, "_novr"}, oq.size() - bo, 0);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    tbl = '{'{8'h35, 1'b1, 1'b1, 1'b0}, '{8'h00, 1'b1, 1'b1, 1'b0}, '{8'hFF, 1'b1, 1'b1, 1'b0},
            '{8'hA5, 1'b1, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b0, 1'b1}, '{8'hC3, 1'b0, 1'b0, 1'b1},
            '{8'h01, 1'b1, 1'b1, 1'b0}};
    if_d.rxready = 1'b1;
    if_f.rxready = 1'b1;
    idle(3);
    chk("reset_d", {if_d.rxbyte, if_d.rxvalid, if_d.rxerr, if_d.rxovr}, 0);
    chk("reset_f", {if_f.rxbyte, if_f.rxvalid, if_f.rxerr, if_f.rxovr}, 0);
    rst = 1'b0;
    idle(3);
    // Default 9600 baud: one-cycle valid exactly at t0+11877
    align(t0);
    fork
      frame(8'h35, 1'b1, DCPB);
      begin
        at(t0 + DSTOP - 1);
        chk("dflt_pre_valid", if_d.rxvalid, 0);
        at(t0 + DSTOP);
        chk("dflt_valid", if_d.rxvalid, 1);
        chk("dflt_byte", if_d.rxbyte, 8'h35);
        chk("dflt_flags", {if_d.rxerr, if_d.rxovr}, 0);
        at(t0 + DSTOP + 1);
        chk("dflt_post_valid", if_d.rxvalid, 0);
      end
    join
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    for (int i = 0; i < 7; i++) begin
      snap();
      align(t0);
      frame(tbl[i].d, tbl[i].stop, FCPB);
      idle(4);
      chk($sformatf("tbl%0d_nvalid", i), vq.size() - bv, tbl[i].exp_v);
      chk($sformatf("tbl%0d_nerr", i), eq.size() - be, tbl[i].exp_e);
      chk($sformatf("tbl%0d_novr", i), oq.size() - bo, 0);
      if (tbl[i].exp_v && vq.size() > bv) chk($sformatf("tbl%0d_cycle", i), vq[bv], t0 + FSTOP);
      if (tbl[i].exp_v && xq.size() > bx) chk($sformatf("tbl%0d_byte", i), xq[bx], tbl[i].d);
      if (tbl[i].exp_e && eq.size() > be) chk($sformatf("tbl%0d_errcyc", i), eq[be], t0 + FSTOP);
    end
    // Line held low for 20 bit times: a single error, then normal reception
    snap();
    align(t0);
    ftdi = 1'b0;
    idle(20 * FCPB);
    ftdi = 1'b1;
    idle(2 * FCPB);
    chk("brk_nerr", eq.size() - be, 1);
    if (eq.size() > be) chk("brk_errcyc", eq[be], t0 + FSTOP);
    chk("brk_nvalid", vq.size() - bv, 0);
    snap();
    align(t0);
    frame(8'h55, 1'b1, FCPB);
    idle(4);
    expect_one("brk_after", 8'h55, t0);
    // Short glitch, then a start bit on the earliest edge the receiver can be idle again
    snap();
    align(t0);
    ftdi = 1'b0;
    idle(FHALF - 2);
    ftdi = 1'b1;
    idle(3);
    t1 = cyc + 1;
    chk("glitch_t1", t1, t0 + FHALF + 1);
    frame(8'h3C, 1'b1, FCPB);
    idle(4);
    expect_one("glitch", 8'h3C, t1);
    // Back-to-back frames with a slow consumer
    if_f.rxready = 1'b0;
    snap();
    fork
      for (int b = 0; b < 10; b++) frame(8'(8'h30 + b), 1'b1, FCPB);
      for (int k = 0; k < 10; k++) begin
        w = 0;
        while (!if_f.rxvalid && w < 20 * FCPB) begin
          @(negedge hwclk);
          w++;
        end
        chk($sformatf("b2b%0d_wait", k), if_f.rxvalid, 1);
        repeat ($urandom_range(100, 1)) @(posedge hwclk);
        #1 if_f.rxready = 1'b1;
        @(posedge hwclk);
        #1 if_f.rxready = 1'b0;
      end
    join
    idle(4);
    chk("b2b_nxfer", xq.size() - bx, 10);
    for (int k = 0; k < 10; k++)
      if (xq.size() > bx + k) chk($sformatf("b2b%0d_byte", k), xq[bx + k], 8'h30 + k);
    chk("b2b_novr", oq.size() - bo, 0);
    chk("b2b_nerr", eq.size() - be, 0);
    // Overrun: second byte dropped, first byte held
    snap();
    align(t0);
    frame(8'h41, 1'b1, FCPB);
    align(t1);
    frame(8'h42, 1'b1, FCPB);
    idle(4);
    chk("ovr_novr", oq.size() - bo, 1);
    if (oq.size() > bo) chk("ovr_cycle", oq[bo], t1 + FSTOP);
    chk("ovr_held", {if_f.rxvalid, if_f.rxbyte}, {1'b1, 8'h41});
    chk("ovr_nvalid", vq.size() - bv, 1);
    if_f.rxready = 1'b1;
    idle(1);
    chk("ovr_drained", if_f.rxvalid, 0);
    if (xq.size() > bx) chk("ovr_xfer", xq[bx], 8'h41);
    else chk("ovr_nxfer", xq.size() - bx, 1);
    // Random frames, about one in six with a bad stop bit
    snap();
    nerr = 0;
    for (int r = 0; r < 30; r++) begin
      logic [7:0] d;
      bit s;
      d = 8'($urandom);
      s = $urandom_range(5, 0) != 0;
      if (s) exp_q.push_back(d);
      else nerr++;
      align(t0);
      frame(d, s, FCPB);
      idle($urandom_range(20, 0));
    end
    idle(4);
    chk("rnd_nxfer", xq.size() - bx, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (xq.size() > bx + k) chk($sformatf("rnd%0d_byte", k), xq[bx + k], exp_q[k]);
    chk("rnd_nerr", eq.size() - be, nerr);
    chk("rnd_novr", oq.size() - bo, 0);
    // Asynchronous reset during bit 4 while a byte is pending
    if_f.rxready = 1'b0;
    align(t0);
    frame(8'h77, 1'b1, FCPB);
    idle(2);
    align(t0);
    fork
      frame(8'hA5, 1'b1, FCPB);
      begin
        at(t0 + 5 * FCPB + FCPB / 2);
        chk("rstmid_pending", {if_f.rxvalid, if_f.rxbyte}, {1'b1, 8'h77});
        rst = 1'b1;
        #1;
        chk("rstmid_out", {if_f.rxbyte, if_f.rxvalid, if_f.rxerr, if_f.rxovr}, 0);
      end
    join
    idle(4);
    rst = 1'b0;
    if_f.rxready = 1'b1;
    idle(4);
    snap();
    align(t0);
    frame(8'h5A, 1'b1, FCPB);
    idle(4);
    expect_one("rst_after", 8'h5A, t0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
